instr_cache_data_array: RTL
===========================

INSTR_CACHE_DATA_ARRAY -- requirements
Module: instr_cache_data_array

Interface
REQ-001 SHALL have parameter ASSOC, default 4: number of ways.
REQ-002 SHALL have parameter SETS, default 64: sets per way, power of 2.
REQ-003 SHALL have parameter LINE_BYTES, default 32: line size, power of 2.
REQ-004 SHALL have parameter FETCH_BYTES, default 8: read word width per way, power of 2, at most LINE_BYTES.
REQ-005 SHALL have parameter BEAT_BYTES, default 8: refill beat width, power of 2, at most LINE_BYTES.
REQ-006 SHALL have parameter PADDR_WIDTH, default `PADDR_WIDTH: address width.
REQ-007 SHALL have port i_clk  in  1  clock.
REQ-008 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port i_rd_valid  in  1  read request.
REQ-010 SHALL have port i_rd_vaddr  in  PADDR_WIDTH  fetch address.
REQ-011 SHALL have port o_rd_valid  out  1  read data valid.
REQ-012 SHALL have port o_rd_data  out  ASSOC x FETCH_BYTES*8  per-way read word.
REQ-013 SHALL have port o_rd_hazard  out  1  read hit the set under refill.
REQ-014 SHALL have port i_fill_start  in  1  begin line refill.
REQ-015 SHALL have port i_fill_set  in  log2(SETS)  target set.
REQ-016 SHALL have port i_fill_way  in  log2(ASSOC)  target way.
REQ-017 SHALL have port i_fill_valid  in  1  beat valid.
REQ-018 SHALL have port i_fill_data  in  BEAT_BYTES*8  beat payload.
REQ-019 SHALL have port o_fill_ready  out  1  beat accepted when high with i_fill_valid.
REQ-020 SHALL have port i_fill_abort  in  1  cancel refill.
REQ-021 SHALL have port o_fill_done  out  1  one-cycle completion pulse.

Function
REQ-022 SHALL decode: offset = vaddr[log2(LINE_BYTES)-1:0], set = next log2(SETS) bits, word = offset / FETCH_BYTES.
REQ-023 SHALL register reads with 1-cycle latency: o_rd_valid(t+1) = i_rd_valid(t), o_rd_data(t+1) = word of every way at the set sampled at t.
REQ-024 SHALL hold o_rd_data when i_rd_valid is low.
REQ-025 SHALL implement FSM IDLE -> FILL on i_fill_start, latching set, way and beat counter 0.
REQ-026 SHALL ignore i_fill_start outside IDLE.
REQ-027 SHALL drive o_fill_ready=1 only in FILL.
REQ-028 SHALL write each accepted beat to byte offset counter*BEAT_BYTES of the latched line, then increment the counter.
REQ-029 SHALL go FILL -> DONE after beat LINE_BYTES/BEAT_BYTES-1 is accepted, and DONE -> IDLE after one cycle.
REQ-030 SHALL assert o_fill_done only in DONE.
REQ-031 SHALL return from FILL to IDLE on i_fill_abort without o_fill_done; abort takes priority over a same-cycle beat, which is not written; already written beats remain.
REQ-032 SHALL assert o_rd_hazard(t+1) with o_rd_valid when the read set at t equals the latched set and the FSM is FILL or DONE; all way data is still returned.
REQ-033 SHALL return pre-write data for a read and a beat write to the same location in the same cycle.

Reset
REQ-034 SHALL on reset set FSM IDLE, counter 0, o_rd_valid, o_rd_hazard, o_fill_ready, o_fill_done and o_rd_data to 0.
REQ-035 SHALL clear all storage to 0 on reset; reset mid-fill abandons the fill with no o_fill_done.

Structure
REQ-036 SHALL take the default ASSOC and line geometry constants from config.sv and the per-way read-word type from types.sv, generalising icache_data_unit_t.
REQ-037 SHALL instantiate sub-module instr_cache_data_way once per way: storage, beat write and registered read.

Verification
REQ-038 Reset, then read 0x000 -> o_rd_valid=1 next cycle, all ways 0, hazard 0.
REQ-039 Fill set 5 way 2 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> done pulse 1 cycle after 4th beat; read 0x0B0 -> way2 = 0x33..33, others 0.
REQ-040 Mid-fill read set 5 -> o_rd_hazard=1; read set 6 -> hazard 0.
REQ-041 Abort after 2 beats on set 7 way 0 -> no done pulse, FSM IDLE, words 0-1 written, words 2-3 remain 0.
REQ-042 Beat stalled (i_fill_valid low 3 cycles) -> counter held, no write; i_fill_start during FILL ignored.
REQ-043 Async reset asserted mid-fill -> all outputs 0 immediately, storage cleared, no done pulse.

Source files
------------

// File: rtl/instr_cache_data_array_pkg.sv
// instr_cache_data_array_pkg: shared instruction-cache data-array geometry, fill FSM states and helpers
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
package instr_cache_data_array_pkg;
  localparam int ICACHE_ASSOC       = 4;
  localparam int ICACHE_SETS        = 64;
  localparam int ICACHE_LINE_BYTES  = 32;
  localparam int ICACHE_FETCH_BYTES = 8;
  localparam int ICACHE_BEAT_BYTES  = 8;
  typedef logic [ICACHE_FETCH_BYTES*8-1:0] icache_data_unit_t;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} fill_state_e;
  function automatic int clog2_min1(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/instr_cache_data_way.sv
// instr_cache_data_way: one way of line storage with beat-granular writes and a registered fetch-word read
module instr_cache_data_way
  import instr_cache_data_array_pkg::*;
#(
  parameter int SETS        = ICACHE_SETS,
  parameter int LINE_BYTES  = ICACHE_LINE_BYTES,
  parameter int FETCH_BYTES = ICACHE_FETCH_BYTES,
  parameter int BEAT_BYTES  = ICACHE_BEAT_BYTES,
  localparam int SET_W      = clog2_min1(SETS),
  localparam int OFF_W      = clog2_min1(LINE_BYTES),
  localparam int BEAT_W     = clog2_min1(LINE_BYTES / BEAT_BYTES)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rd_en,
  input  logic [SET_W-1:0]         i_rd_set,
  input  logic [OFF_W-1:0]         i_rd_off,
  output logic [FETCH_BYTES*8-1:0] o_rd_data,
  input  logic                     i_wr_en,
  input  logic [SET_W-1:0]         i_wr_set,
  input  logic [BEAT_W-1:0]        i_wr_beat,
  input  logic [BEAT_BYTES*8-1:0]  i_wr_data
);
  logic [LINE_BYTES*8-1:0]  r_mem [SETS];
  logic [FETCH_BYTES*8-1:0] r_rd_data;
  assign o_rd_data = r_rd_data;
  // Flop-based storage so reset can clear every line; a beat overwrites its slice of the line
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      for (int s = 0; s < SETS; s++) r_mem[s] <= '0;
    else if (i_wr_en)
      r_mem[i_wr_set][int'(i_wr_beat)*BEAT_BYTES*8 +: BEAT_BYTES*8] <= i_wr_data;
  // Registered read sees pre-write contents on a same-cycle collision and holds when not enabled
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      r_rd_data <= '0;
    else if (i_rd_en)
      r_rd_data <= r_mem[i_rd_set][(int'(i_rd_off) / FETCH_BYTES)*FETCH_BYTES*8 +: FETCH_BYTES*8];
endmodule

// File: rtl/instr_cache_data_array.sv
// instr_cache_data_array: set-associative instruction data array with per-way reads and a line-refill FSM
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
module instr_cache_data_array
  import instr_cache_data_array_pkg::*;
#(
  parameter int ASSOC       = ICACHE_ASSOC,
  parameter int SETS        = ICACHE_SETS,
  parameter int LINE_BYTES  = ICACHE_LINE_BYTES,
  parameter int FETCH_BYTES = ICACHE_FETCH_BYTES,
  parameter int BEAT_BYTES  = ICACHE_BEAT_BYTES,
  parameter int PADDR_WIDTH = `PADDR_WIDTH,
  localparam int SET_W      = clog2_min1(SETS),
  localparam int WAY_W      = clog2_min1(ASSOC),
  localparam int OFF_W      = clog2_min1(LINE_BYTES),
  localparam int BEATS      = LINE_BYTES / BEAT_BYTES,
  localparam int BEAT_W     = clog2_min1(BEATS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_rd_valid,
  input  logic [PADDR_WIDTH-1:0]         i_rd_vaddr,
  output logic                           o_rd_valid,
  output logic [ASSOC*FETCH_BYTES*8-1:0] o_rd_data,
  output logic                           o_rd_hazard,
  input  logic                           i_fill_start,
  input  logic [SET_W-1:0]               i_fill_set,
  input  logic [WAY_W-1:0]               i_fill_way,
  input  logic                           i_fill_valid,
  input  logic [BEAT_BYTES*8-1:0]        i_fill_data,
  output logic                           o_fill_ready,
  input  logic                           i_fill_abort,
  output logic                           o_fill_done
);
  fill_state_e       r_state, w_state_nxt;
  logic [SET_W-1:0]  r_fill_set, w_rd_set;
  logic [WAY_W-1:0]  r_fill_way;
  logic [BEAT_W-1:0] r_beat;
  logic [OFF_W-1:0]  w_rd_off;
  logic              r_rd_valid, r_rd_hazard, w_beat_acc, w_last_beat, w_unused;
  assign w_rd_off     = i_rd_vaddr[OFF_W-1:0];
  assign w_rd_set     = i_rd_vaddr[OFF_W +: SET_W];
  assign w_unused     = ^i_rd_vaddr[PADDR_WIDTH-1:OFF_W+SET_W];
  assign w_beat_acc   = r_state == ST_FILL && i_fill_valid && !i_fill_abort;
  assign w_last_beat  = r_beat == BEAT_W'(BEATS - 1);
  assign o_fill_ready = r_state == ST_FILL;
  assign o_fill_done  = r_state == ST_DONE;
  assign o_rd_valid   = r_rd_valid;
  assign o_rd_hazard  = r_rd_hazard;
  // Next state: start honoured only in IDLE, abort beats a same-cycle beat, DONE lasts one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = r_state == ST_IDLE ? (i_fill_start ? ST_FILL : ST_IDLE) :
                  r_state == ST_FILL ? (i_fill_abort ? ST_IDLE : (w_beat_acc && w_last_beat) ? ST_DONE : ST_FILL) :
                  ST_IDLE;
  end
  // Fill FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  // Latch refill target on start and advance the beat counter on each accepted beat
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_fill_set <= '0;
      r_fill_way <= '0;
      r_beat     <= '0;
    end else if (r_state == ST_IDLE && i_fill_start) begin
      r_fill_set <= i_fill_set;
      r_fill_way <= i_fill_way;
      r_beat     <= '0;
    end else if (w_beat_acc)
      r_beat <= r_beat + 1'b1;
  // Read valid and hazard flag, aligned with the registered read data
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_rd_valid  <= 1'b0;
      r_rd_hazard <= 1'b0;
    end else begin
      r_rd_valid  <= i_rd_valid;
      r_rd_hazard <= i_rd_valid && w_rd_set == r_fill_set && (r_state == ST_FILL || r_state == ST_DONE);
    end
  for (genvar g = 0; g < ASSOC; g++) begin : g_way
    instr_cache_data_way #(
      .SETS       (SETS),
      .LINE_BYTES (LINE_BYTES),
      .FETCH_BYTES(FETCH_BYTES),
      .BEAT_BYTES (BEAT_BYTES)
    ) u_way (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_rd_en  (i_rd_valid),
      .i_rd_set (w_rd_set),
      .i_rd_off (w_rd_off),
      .o_rd_data(o_rd_data[g*FETCH_BYTES*8 +: FETCH_BYTES*8]),
      .i_wr_en  (w_beat_acc && r_fill_way == WAY_W'(g)),
      .i_wr_set (r_fill_set),
      .i_wr_beat(r_beat),
      .i_wr_data(i_fill_data)
    );
  end
endmodule
